// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: funct3 width codes,
// FSM state encodings and fault codes.
package lsu_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_e;

   localparam logic [1:0] LSU_F_NONE  = 2'b00;
   localparam logic [1:0] LSU_F_MISAL = 2'b01;
   localparam logic [1:0] LSU_F_ILL   = 2'b10;
   localparam logic [1:0] LSU_F_TMO   = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane replication,
// load extraction/extension and access legality flags.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misal_o,
   output logic        ill_o
);

   logic [31:0] shifted;

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      shifted = rdata_i >> {off_i, 3'b000};

      if (we_i)
         ill_o = funct3_i[2] | (funct3_i == 3'b011);
      else
         ill_o = (funct3_i == 3'b011) | (funct3_i == 3'b110)
               | (funct3_i == 3'b111);

      misal_o = ((funct3_i[1:0] == 2'b01) & off_i[0])
              | ((funct3_i[1:0] == 2'b10) & (off_i != 2'b00));

      if (we_i) begin
         case (funct3_i[1:0])
            2'b00: begin
               be_o    = 4'b0001 << off_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
               be_o    = off_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
               be_o    = 4'b1111;
               wdata_o = wdata_i;
            end
         endcase
      end else begin
         case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata_o = {24'd0, shifted[7:0]};
            F3_HU:   rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = rdata_i;
         endcase
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: req/ack bus FSM with capture registers,
// stall generation, fault reporting and a bus timeout counter.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   lsu_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic [1:0]  fcode_q, fcode_d;
   logic        stall_c;

   logic        in_req;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;
   logic        al_misal, al_ill;

   assign in_req = (state_q == LSU_REQ);

   // Live inputs are checked in IDLE; captured ones drive load extraction.
   lsu_align u_align (
      .we_i     (in_req ? we_q : mem_we),
      .funct3_i (in_req ? f3_q : funct3),
      .off_i    (in_req ? addr_q[1:0] : addr[1:0]),
      .wdata_i  (wdata),
      .rdata_i  (bus_rdata),
      .be_o     (al_be),
      .wdata_o  (al_wdata),
      .rdata_o  (al_rdata),
      .misal_o  (al_misal),
      .ill_o    (al_ill)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LSU_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         fcode_q <= LSU_F_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         fcode_q <= fcode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      fcode_d = fcode_q;
      stall_c = 1'b0;

      unique case (state_q)
         LSU_IDLE: begin
            cnt_d   = '0;
            fault_d = 1'b0;
            fcode_d = LSU_F_NONE;
            if (mem_valid) begin
               if (al_ill || al_misal) begin
                  state_d = LSU_DONE;
                  fault_d = 1'b1;
                  fcode_d = al_ill ? LSU_F_ILL : LSU_F_MISAL;
               end else begin
                  state_d = LSU_REQ;
                  stall_c = 1'b1;
                  addr_d  = addr;
                  f3_d    = funct3;
                  we_d    = mem_we;
                  wdata_d = al_wdata;
                  be_d    = al_be;
               end
            end
         end
         LSU_REQ: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_ONE;
            // Ack beats a coincident timeout.
            if (bus_ack) begin
               state_d = LSU_DONE;
               if (!we_q)
                  rdata_d = al_rdata;
            end else if (cnt_q == TMO_LAST) begin
               state_d = LSU_DONE;
               rdata_d = '0;
               fault_d = 1'b1;
               fcode_d = LSU_F_TMO;
            end
         end
         LSU_DONE: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   assign stall      = stall_c & ~reset;
   assign readdata   = rdata_q;
   assign fault      = (state_q == LSU_DONE) & fault_q;
   assign fault_code = fault ? fcode_q : LSU_F_NONE;
   assign bus_req    = in_req;
   assign bus_we     = in_req & we_q;
   assign bus_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus_wdata  = in_req ? wdata_q : 32'd0;
   assign bus_be     = in_req ? be_q : 4'b0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT=4) with hand-computed expectations.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] readdata;
   logic        stall;
   logic        fault;
   logic [1:0]  fault_code;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int errs = 0;
   int checks = 0;

   int          r_stalls, r_nreq;
   logic        r_done, r_flt, r_we;
   logic [1:0]  r_code;
   logic [31:0] r_rd, r_addr, r_wd;
   logic [3:0]  r_be;

   lsu_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .readdata   (readdata),
      .stall      (stall),
      .fault      (fault),
      .fault_code (fault_code),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_be     (bus_be),
      .bus_ack    (bus_ack),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Runs one access from IDLE; ack_at=0 means never ack.
   task automatic acc(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int ack_at, input logic [31:0] rd);
      r_stalls = 0; r_nreq = 0; r_done = 1'b0;
      r_addr = '0; r_be = '0; r_wd = '0; r_we = 1'b0;
      r_flt = 1'b0; r_code = '0; r_rd = '0;
      mem_valid = 1'b1; mem_we = we; funct3 = f3;
      addr = a; wdata = wd; bus_rdata = rd;
      for (int i = 0; i < 20 && !r_done; i++) begin
         #1;
         if (stall) r_stalls++;
         if (bus_req) begin
            r_nreq++;
            if (r_nreq == 1) begin
               r_addr = bus_addr; r_be = bus_be;
               r_wd = bus_wdata; r_we = bus_we;
            end
            bus_ack = (r_nreq == ack_at);
         end
         @(posedge clk); #2;
         bus_ack = 1'b0;
         if (!stall) begin
            r_done = 1'b1;
            r_rd = readdata; r_flt = fault; r_code = fault_code;
         end
      end
      if (!r_done) chk("acc_bound", 32'd0, 32'd1);
      mem_valid = 1'b0;
      @(posedge clk); #2;
      chk("fault_one_cycle", {31'd0, fault}, 32'd0);
   endtask

   initial begin
      mem_valid = 1'b1; funct3 = 3'b010; addr = 32'h1000;
      #12;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_rd", readdata, 32'd0);
      chk("rst_misc", {bus_be, bus_we, fault, fault_code}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wd", bus_wdata, 32'd0);
      mem_valid = 1'b0;
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #2;

      acc(1'b0, 3'b010, 32'h1000, 32'd0, 3, 32'hDEADBEEF);
      chk("lw_stalls", r_stalls, 4);
      chk("lw_addr", r_addr, 32'h1000);
      chk("lw_be", {28'd0, r_be}, 32'hF);
      chk("lw_we", {31'd0, r_we}, 32'd0);
      chk("lw_rd", r_rd, 32'hDEADBEEF);
      chk("lw_flt", {31'd0, r_flt}, 32'd0);

      acc(1'b0, 3'b000, 32'h2003, 32'd0, 1, 32'h80123456);
      chk("lb_rd", r_rd, 32'hFFFFFF80);
      chk("lb_stalls", r_stalls, 2);
      chk("lb_addr", r_addr, 32'h2000);
      acc(1'b0, 3'b100, 32'h2003, 32'd0, 1, 32'h80123456);
      chk("lbu_rd", r_rd, 32'h00000080);

      acc(1'b0, 3'b001, 32'h5002, 32'd0, 2, 32'h80017FFF);
      chk("lh_rd", r_rd, 32'hFFFF8001);
      acc(1'b0, 3'b101, 32'h5002, 32'd0, 2, 32'h80017FFF);
      chk("lhu_rd", r_rd, 32'h00008001);

      acc(1'b1, 3'b001, 32'h3002, 32'h0000ABCD, 1, 32'd0);
      chk("sh_we", {31'd0, r_we}, 32'd1);
      chk("sh_be", {28'd0, r_be}, 32'hC);
      chk("sh_wd", r_wd, 32'hABCDABCD);
      chk("sh_addr", r_addr, 32'h3000);
      chk("st_rd_hold", r_rd, 32'h00008001);

      acc(1'b1, 3'b000, 32'h4001, 32'h12345677, 1, 32'd0);
      chk("sb_be", {28'd0, r_be}, 32'h2);
      chk("sb_wd", r_wd, 32'h77777777);
      acc(1'b1, 3'b010, 32'h4008, 32'hCAFE0001, 1, 32'd0);
      chk("sw_be", {28'd0, r_be}, 32'hF);
      chk("sw_wd", r_wd, 32'hCAFE0001);

      acc(1'b0, 3'b010, 32'h1002, 32'd0, 1, 32'd0);
      chk("mis_req", r_nreq, 0);
      chk("mis_stall", r_stalls, 0);
      chk("mis_flt", {31'd0, r_flt}, 32'd1);
      chk("mis_code", {30'd0, r_code}, 32'd1);
      acc(1'b1, 3'b001, 32'h1001, 32'd0, 1, 32'd0);
      chk("mis_sh_code", {30'd0, r_code}, 32'd1);

      acc(1'b0, 3'b011, 32'h1000, 32'd0, 1, 32'd0);
      chk("ill_req", r_nreq, 0);
      chk("ill_code", {30'd0, r_code}, 32'd2);
      acc(1'b1, 3'b100, 32'h1000, 32'd0, 1, 32'd0);
      chk("ill_st_code", {30'd0, r_code}, 32'd2);
      acc(1'b0, 3'b110, 32'h1001, 32'd0, 1, 32'd0);
      chk("ill_prio_code", {30'd0, r_code}, 32'd2);

      acc(1'b0, 3'b010, 32'h6000, 32'd0, 0, 32'h11111111);
      chk("tmo_req", r_nreq, 4);
      chk("tmo_stalls", r_stalls, 5);
      chk("tmo_flt", {31'd0, r_flt}, 32'd1);
      chk("tmo_code", {30'd0, r_code}, 32'd3);
      chk("tmo_rd", r_rd, 32'd0);

      acc(1'b0, 3'b010, 32'h6000, 32'd0, 4, 32'hCAFEF00D);
      chk("ack4_req", r_nreq, 4);
      chk("ack4_flt", {31'd0, r_flt}, 32'd0);
      chk("ack4_rd", r_rd, 32'hCAFEF00D);

      mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010;
      addr = 32'h7000;
      @(posedge clk); #2;
      chk("mid_req_on", {31'd0, bus_req}, 32'd1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("mid_req_off", {31'd0, bus_req}, 32'd0);
      chk("mid_stall_off", {31'd0, stall}, 32'd0);
      chk("mid_rd_off", readdata, 32'd0);
      chk("mid_addr_off", bus_addr, 32'd0);
      mem_valid = 1'b0;
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #2;

      acc(1'b0, 3'b010, 32'h1000, 32'd0, 2, 32'h0BADF00D);
      chk("post_rst_rd", r_rd, 32'h0BADF00D);
      chk("post_rst_stalls", r_stalls, 3);
      chk("post_rst_flt", {31'd0, r_flt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly downstream of the single-cycle datapath. It consumes the datapath's ALU result (used as the address), its store data and the instruction's funct3. It drives a req/ack data-memory bus, returns aligned, extended load data on readdata, and holds the core with a stall while a bus transfer is in flight. It also covers alignment checks, byte enables and a bus timeout.

Parameters:
TIMEOUT, 255, max cycles to wait for bus_ack before aborting with a timeout fault (1..255)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
mem_valid  input  1  current instruction is a load or store (held stable by datapath while stall=1)
mem_we  input  1  1=store, 0=load
funct3  input  3  RV32I width/sign code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
addr  input  32  byte address (datapath aluout)
wdata  input  32  store data (datapath writedata)
readdata  output  32  extended load result to datapath result mux
stall  output  1  hold PC/regfile write this cycle
fault  output  1  one-cycle pulse: access aborted
fault_code  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid when fault=1
bus_req  output  1  request to data memory
bus_we  output  1  request is a write
bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_be  output  4  byte enables
bus_ack  input  1  memory completes request (single-cycle pulse)
bus_rdata  input  32  read word; sampled in the ack cycle

Behaviour:
- Reset (async): state IDLE, counter 0, captured regs 0. All outputs 0: bus_req, bus_we, bus_be, bus_addr, bus_wdata, readdata, stall, fault and fault_code.
- States: IDLE, REQ, DONE (encodings in shared package).
- IDLE + mem_valid + legal access: register addr, funct3, we, aligned wdata and be. Go to REQ. stall=1 combinationally in this cycle.
- IDLE + mem_valid + violation: no bus request and stall=0. Go to DONE with fault latched for the DONE cycle.
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Illegal funct3: load 011/110/111, or store funct3[2]=1 or 011.
  - Illegal funct3 takes priority over misaligned.
- REQ:
  - bus_req=1 and bus_* driven from the captured registers. stall=1.
  - Counter increments each cycle.
  - bus_ack=1: capture extended load data and go to DONE.
  - Counter reaches TIMEOUT with no ack: go to DONE with fault_code=11 and readdata=0.
  - Ack in the same cycle as the timeout: ack wins, no fault.
- DONE:
  - stall=0. readdata holds the registered result; fault pulses if latched.
  - Unconditional return to IDLE, even though mem_valid is still high for the same instruction. No re-issue.
  - Back-to-back memory instructions start a new access in the next IDLE.
- Latency: load with ack after N cycles in REQ stalls for N+1 cycles; readdata is valid in the DONE cycle.
- Store alignment:
  - SB: be=0001<<addr[1:0], wdata[7:0] replicated on all 4 lanes.
  - SH: be = addr[1] ? 1100 : 0011, wdata[15:0] replicated twice.
  - SW: be=1111.
- Loads: bus_be=1111. Extract byte/half at offset addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- bus_ack outside REQ is ignored. readdata holds its last value outside DONE.
- Reset asserted during REQ drops bus_req immediately; the memory must tolerate an abandoned request.

Decomposition:
- Shared package consts.v gets:
  - funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - LSU state encodings (LSU_IDLE, LSU_REQ, LSU_DONE)
  - fault codes (LSU_F_NONE, LSU_F_MISAL, LSU_F_ILL, LSU_F_TMO)
- One combinational sub-module, lsu_align:
  - inputs: funct3, addr[1:0], wdata, bus_rdata
  - outputs: bus_be, lane wdata, extended load data, misaligned/illegal flags
- lsu_ctrl keeps the FSM, counter and capture registers.

Test Plan:
- LW addr 0x1000, bus_rdata 0xDEADBEEF, ack on 3rd REQ cycle -> bus_addr 0x1000, be 1111, stall high 4 cycles, readdata 0xDEADBEEF in DONE.
- LB addr 0x2003, bus_rdata 0x80123456 -> readdata 0xFFFFFF80; repeat with LBU -> 0x00000080.
- SH addr 0x3002, wdata 0x0000ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, bus_addr 0x3000.
- LW addr 0x1002 -> no bus_req, stall 0, fault pulse with code 01 next cycle; load funct3 011 -> code 10.
- Load with TIMEOUT=4 and no ack -> bus_req held 4 cycles, then DONE with fault code 11, readdata 0. Ack on the 4th cycle -> normal completion, no fault.
- Assert reset mid-REQ -> bus_req, stall and readdata go 0 without waiting for clk. A following LW completes normally.
